// File: rtl/aes_byte_packer.sv
// aes_byte_packer: gathers a valid/ready byte stream into 128-bit blocks,
// pads the final block (PKCS#7 or zeros) and feeds them one at a time to
// the aes core, stalling the byte stream while a block is outstanding.
module aes_byte_packer #(
    parameter bit PAD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid_in,
    output logic             byte_ready_out,
    input  logic [7:0]       byte_in,
    input  logic             byte_last_in,
    input  logic [127:0]     key_in,
    output logic             aes_data_valid_out,
    output logic [127:0]     aes_data_out,
    output logic [127:0]     aes_key_out,
    input  logic             aes_res_valid_in,
    output logic             msg_done_out,
    output logic [CNT_W-1:0] blocks_issued_out
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PAD   = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic [15:0][7:0]  buf_q,        buf_d;   // buf_q[15] is byte index 0 (MSB)
    logic              extra_pad_q,  extra_pad_d;
    logic              last_blk_q,   last_blk_d;
    logic              data_valid_q, data_valid_d;
    logic [127:0]      data_q,       data_d;
    logic [127:0]      key_q,        key_d;
    logic              done_q,       done_d;
    logic [CNT_W-1:0]  issued_q,     issued_d;

    logic              accept;
    logic [7:0]        pad_byte;

    assign byte_ready_out = (state_q == S_FILL) && !reset;
    assign accept         = byte_ready_out && byte_valid_in;

    // With cnt_q = n valid bytes, PKCS#7 fills with 16-n; n = 0 gives 0x10.
    assign pad_byte = PAD_EN ? (8'd16 - {4'd0, cnt_q}) : 8'd0;

    // Next-state, buffer update and output-register inputs.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        extra_pad_d  = extra_pad_q;
        last_blk_d   = last_blk_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        key_d        = key_q;
        done_d       = 1'b0;
        issued_d     = issued_q;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    buf_d[4'd15 - cnt_q] = byte_in;
                    cnt_d                = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d     = S_ISSUE;
                        extra_pad_d = byte_last_in && PAD_EN;
                        last_blk_d  = byte_last_in && !PAD_EN;
                    end else if (byte_last_in) begin
                        state_d    = S_PAD;
                        last_blk_d = 1'b1;
                    end
                end
            end
            S_PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (i >= int'(cnt_q)) begin
                        buf_d[15-i] = pad_byte;
                    end
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                data_d       = buf_q;
                key_d        = key_in;
                data_valid_d = 1'b1;
                issued_d     = issued_q + 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (aes_res_valid_in) begin
                    cnt_d = 4'd0;
                    if (extra_pad_q) begin
                        // Full PKCS#7 padding block: 16 bytes of 0x10.
                        state_d     = S_PAD;
                        extra_pad_d = 1'b0;
                        last_blk_d  = 1'b1;
                    end else begin
                        state_d    = S_FILL;
                        done_d     = last_blk_q;
                        last_blk_d = 1'b0;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge.
        if (reset) begin
            state_q      <= S_FILL;
            cnt_q        <= 4'd0;
            extra_pad_q  <= 1'b0;
            last_blk_q   <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            key_q        <= '0;
            done_q       <= 1'b0;
            issued_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            extra_pad_q  <= extra_pad_d;
            last_blk_q   <= last_blk_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            key_q        <= key_d;
            done_q       <= done_d;
            issued_q     <= issued_d;
        end
    end

    // Block assembly buffer.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every byte of a block is written or padded
        // before it is issued, so stale contents are never visible.
        buf_q <= buf_d;
    end

    assign aes_data_valid_out = data_valid_q;
    assign aes_data_out       = data_q;
    assign aes_key_out        = key_q;
    assign msg_done_out       = done_q;
    assign blocks_issued_out  = issued_q;

endmodule

// File: tb/tb_aes_byte_packer.sv
// Testbench for aes_byte_packer: two instances (zero padding with a 4-bit
// block counter, PKCS#7 with a 16-bit counter), each with its own aes
// responder, checked against a message-level padding/blocking model.
module tb_aes_byte_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         bv [2];
    logic         br [2];
    logic [7:0]   bdat [2];
    logic         bl [2];
    logic [127:0] key [2];
    logic         dv [2];
    logic [127:0] dout [2];
    logic [127:0] kout [2];
    logic         rv [2];
    logic         done [2];
    logic [3:0]   bi0;
    logic [15:0]  bi1;

    aes_byte_packer #(.PAD_EN(1'b0), .CNT_W(4)) dut_zero (
        .clk(clk), .reset(reset),
        .byte_valid_in(bv[0]), .byte_ready_out(br[0]), .byte_in(bdat[0]),
        .byte_last_in(bl[0]), .key_in(key[0]),
        .aes_data_valid_out(dv[0]), .aes_data_out(dout[0]), .aes_key_out(kout[0]),
        .aes_res_valid_in(rv[0]), .msg_done_out(done[0]), .blocks_issued_out(bi0)
    );

    aes_byte_packer #(.PAD_EN(1'b1), .CNT_W(16)) dut_pkcs (
        .clk(clk), .reset(reset),
        .byte_valid_in(bv[1]), .byte_ready_out(br[1]), .byte_in(bdat[1]),
        .byte_last_in(bl[1]), .key_in(key[1]),
        .aes_data_valid_out(dv[1]), .aes_data_out(dout[1]), .aes_key_out(kout[1]),
        .aes_res_valid_in(rv[1]), .msg_done_out(done[1]), .blocks_issued_out(bi1)
    );

    localparam bit PAD_OF [2] = '{1'b0, 1'b1};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]   msg_buf [$];
    logic [127:0] exp_blk_q [2][$];
    logic [127:0] exp_key_q [2][$];
    bit           exp_fin_q [2][$];
    int           exp_cyc_q [2][$];   // -1: issue time not checked
    int           res_delay [2];
    int           res_cyc [2];
    int           done_cnt [2];
    int           msgs_sent [2];
    int           total_blk [2];
    bit           last_final [2];
    bit           busy [2];
    logic [127:0] last_data [2];

    // Per-instance monitor (issues, msg_done) and aes responder
    for (genvar g = 0; g < 2; g++) begin : g_side
        always begin
            @(posedge clk); #1;
            if (dv[g]) begin
                n_cmp++;
                if (exp_blk_q[g].size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_issue dut%0d: got data %h, expected no issue", g, dout[g]);
                end else begin
                    logic [127:0] eb, ek;
                    int ec;
                    eb = exp_blk_q[g].pop_front();
                    ek = exp_key_q[g].pop_front();
                    last_final[g] = exp_fin_q[g].pop_front();
                    ec = exp_cyc_q[g].pop_front();
                    if (dout[g] !== eb) begin
                        n_err++;
                        $display("FAIL block_data dut%0d: got %h expected %h", g, dout[g], eb);
                    end
                    n_cmp++;
                    if (kout[g] !== ek) begin
                        n_err++;
                        $display("FAIL block_key dut%0d: got %h expected %h", g, kout[g], ek);
                    end
                    if (ec >= 0) begin
                        n_cmp++;
                        if (cyc != ec) begin
                            n_err++;
                            $display("FAIL issue_time dut%0d: got cycle %0d expected %0d", g, cyc, ec);
                        end
                    end
                    busy[g] = 1'b1;
                end
                last_data[g] = dout[g];
            end
            if (done[g]) begin
                done_cnt[g]++;
                n_cmp++;
                if (!last_final[g] || cyc != res_cyc[g]) begin
                    n_err++;
                    $display("FAIL msg_done dut%0d: got pulse at cycle %0d (final=%0d) expected cycle %0d after final result",
                             g, cyc, last_final[g], res_cyc[g]);
                end
                last_final[g] = 1'b0;
            end
        end

        always begin
            @(posedge clk); #1;
            if (dv[g]) begin
                for (int w = 0; w <= res_delay[g]; w++) begin
                    if (w > 0) begin
                        @(posedge clk); #1;
                    end
                    n_cmp++;
                    if (br[g] !== 1'b0) begin
                        n_err++;
                        $display("FAIL ready_in_wait dut%0d: got %b expected 0", g, br[g]);
                    end
                end
                rv[g] = 1'b1;
                res_cyc[g] = cyc + 1;
                @(posedge clk); #1;
                rv[g] = 1'b0;
                begin
                    bit exp_r;
                    exp_r = !(exp_cyc_q[g].size() > 0 && exp_cyc_q[g][0] == -1);
                    n_cmp++;
                    if (br[g] !== exp_r) begin
                        n_err++;
                        $display("FAIL ready_after_result dut%0d: got %b expected %b", g, br[g], exp_r);
                    end
                end
                busy[g] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] get_bi(input int d);
        return (d == 0) ? {12'd0, bi0} : bi1;
    endfunction

    task automatic fill_random(input int len);
        msg_buf.delete();
        for (int i = 0; i < len; i++) msg_buf.push_back(8'($urandom));
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Computes expected blocks for msg_buf, then streams it into instance d.
    task automatic send_msg(input int d, input logic [127:0] k, input bit with_last);
        int len;
        int budget;
        len = msg_buf.size();
        if (with_last) begin
            logic [7:0]   padded [$];
            logic [127:0] blk;
            int nb;
            padded = msg_buf;
            if (PAD_OF[d]) begin
                int p;
                p = 16 - (len % 16);
                repeat (p) padded.push_back(8'(p));
            end else begin
                while (padded.size() % 16 != 0) padded.push_back(8'h00);
            end
            nb = padded.size() / 16;
            for (int b = 0; b < nb; b++) begin
                blk = '0;
                for (int i = 0; i < 16; i++) blk = {blk[119:0], padded[16*b+i]};
                exp_blk_q[d].push_back(blk);
                exp_key_q[d].push_back(k);
                exp_fin_q[d].push_back(b == nb - 1);
            end
            total_blk[d] += nb;
            msgs_sent[d]++;
        end
        key[d] = k;
        for (int j = 0; j < len; j++) begin
            bv[d]   = 1'b1;
            bdat[d] = msg_buf[j];
            bl[d]   = with_last && (j == len - 1);
            budget  = 2000;
            while (!br[d] && budget > 0) begin
                @(posedge clk); #1;
                budget--;
            end
            if (budget == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_timeout dut%0d: got no ready for byte %0d, expected ready within 2000 cycles", d, j);
                bv[d] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (j % 16 == 15) exp_cyc_q[d].push_back(cyc + 1);
            else if (bl[d]) exp_cyc_q[d].push_back(cyc + 2);
        end
        if (with_last && PAD_OF[d] && (len % 16 == 0)) exp_cyc_q[d].push_back(-1);
        bv[d]   = 1'b0;
        bdat[d] = 8'($urandom);
        bl[d]   = 1'($urandom);
    endtask

    // Waits until all expected blocks are issued and answered, then checks counters.
    task automatic wait_idle(input int d);
        int budget;
        logic [15:0] exp_bi;
        budget = 2000;
        while ((exp_blk_q[d].size() != 0 || busy[d]) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout dut%0d: got %0d blocks pending, expected 0", d, exp_blk_q[d].size());
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done_cnt[d] != msgs_sent[d]) begin
            n_err++;
            $display("FAIL msg_done_count dut%0d: got %0d expected %0d", d, done_cnt[d], msgs_sent[d]);
        end
        exp_bi = 16'(total_blk[d]) & ((d == 0) ? 16'h000f : 16'hffff);
        n_cmp++;
        if (get_bi(d) !== exp_bi) begin
            n_err++;
            $display("FAIL blocks_issued dut%0d: got %0d expected %0d", d, get_bi(d), exp_bi);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (br[d] !== 1'b0 || dv[d] !== 1'b0 || done[d] !== 1'b0 ||
                dout[d] !== '0 || kout[d] !== '0 || get_bi(d) !== 16'd0) begin
                n_err++;
                $display("FAIL %s dut%0d: got ready=%b valid=%b done=%b data=%h key=%h issued=%0d, expected all zero",
                         tag, d, br[d], dv[d], done[d], dout[d], kout[d], get_bi(d));
            end
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_blk_q[d].delete();
            exp_key_q[d].delete();
            exp_fin_q[d].delete();
            exp_cyc_q[d].delete();
            done_cnt[d]   = 0;
            msgs_sent[d]  = 0;
            total_blk[d]  = 0;
            last_final[d] = 1'b0;
            busy[d]       = 1'b0;
        end
    endtask

    task automatic check_ready_high(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (br[d] !== 1'b1) begin
                n_err++;
                $display("FAIL %s dut%0d: got ready=%b expected 1", tag, d, br[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_reset_outputs("reset_values");
        reset = 1'b0;
        @(posedge clk); #1;
        check_ready_high("ready_after_reset");
    endtask

    task automatic test_zero_pad_vector();
        msg_buf.delete();
        for (int i = 0; i < 16; i++) msg_buf.push_back(8'(i * 17));
        res_delay[0] = 3;
        send_msg(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        wait_idle(0);
        n_cmp++;
        if (last_data[0] !== 128'h00112233445566778899aabbccddeeff ||
            kout[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_err++;
            $display("FAIL vector_block: got data %h key %h expected 00112233445566778899aabbccddeeff / 000102030405060708090a0b0c0d0e0f",
                     last_data[0], kout[0]);
        end
        n_cmp++;
        if (bi0 !== 4'd1 || done_cnt[0] != 1) begin
            n_err++;
            $display("FAIL vector_counts: got issued=%0d done=%0d expected 1 and 1", bi0, done_cnt[0]);
        end
    endtask

    task automatic test_pkcs_short();
        msg_buf.delete();
        msg_buf.push_back(8'h61);
        msg_buf.push_back(8'h62);
        msg_buf.push_back(8'h63);
        res_delay[1] = 2;
        send_msg(1, rand_key(), 1'b1);
        wait_idle(1);
        n_cmp++;
        if (last_data[1] !== 128'h6162630d0d0d0d0d0d0d0d0d0d0d0d0d) begin
            n_err++;
            $display("FAIL pkcs_short: got %h expected 6162630d0d0d0d0d0d0d0d0d0d0d0d0d", last_data[1]);
        end
    endtask

    task automatic test_pkcs_full();
        logic [15:0] bi_before;
        bi_before = bi1;
        fill_random(16);
        res_delay[1] = 4;
        send_msg(1, rand_key(), 1'b1);
        wait_idle(1);
        n_cmp++;
        if (last_data[1] !== {16{8'h10}}) begin
            n_err++;
            $display("FAIL pkcs_full_pad_block: got %h expected 10101010101010101010101010101010", last_data[1]);
        end
        n_cmp++;
        if (bi1 - bi_before !== 16'd2) begin
            n_err++;
            $display("FAIL pkcs_full_issues: got %0d expected 2", bi1 - bi_before);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(32);
        res_delay[0] = 20;
        send_msg(0, rand_key(), 1'b1);
        wait_idle(0);
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 6; m++) begin
                fill_random($urandom_range(1, 40));
                res_delay[d] = $urandom_range(0, 6);
                send_msg(d, rand_key(), 1'b1);
                wait_idle(d);
            end
        end
    endtask

    task automatic test_mid_reset();
        fill_random(7);
        res_delay[1] = 1;
        send_msg(1, rand_key(), 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_reset_outputs("mid_reset_values");
        clear_model();
        reset = 1'b0;
        @(posedge clk); #1;
        check_ready_high("ready_after_mid_reset");
        fill_random(16);
        send_msg(1, rand_key(), 1'b1);
        wait_idle(1);
    endtask

    task automatic test_counter_wrap();
        res_delay[0] = 0;
        for (int m = 0; m < 17; m++) begin
            fill_random(16);
            send_msg(0, rand_key(), 1'b1);
            wait_idle(0);
        end
        n_cmp++;
        if (bi0 !== 4'd1) begin
            n_err++;
            $display("FAIL counter_wrap: got %0d expected 1", bi0);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            bv[d]        = 1'b0;
            bdat[d]      = 8'h00;
            bl[d]        = 1'b0;
            key[d]       = '0;
            rv[d]        = 1'b0;
            res_delay[d] = 1;
            res_cyc[d]   = 0;
            last_data[d] = '0;
        end
        clear_model();
        test_reset();
        test_zero_pad_vector();
        test_pkcs_short();
        test_pkcs_full();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
